// File: rtl/simple_comp_pkg.sv
// Shared types and defaults for the simple_comp scheduler and future
// shared-resource blocks built around the simple_comp unit.
package simple_comp_pkg;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    EXEC     = 2'd2,
    RESP     = 2'd3
  } sc_state_e;

  localparam int SC_DATA_W          = 16;
  localparam int SC_DEFAULT_LATENCY = 2;

  // Counter/index widths must never collapse to zero bits.
  function automatic int sc_max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Scanning offsets from far to near lets the nearest hit overwrite the rest.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/simple_comp_sched.sv
// Round-robin scheduler sharing one simple_comp unit among NUM_REQ requesters,
// one operation in flight, results returned with the requester id.
module simple_comp_sched
  import simple_comp_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = SC_DATA_W,
  parameter  int COMP_LATENCY = SC_DEFAULT_LATENCY,
  localparam int ID_W         = sc_max1($clog2(NUM_REQ))
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_c,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_d,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         comp_a,
  output logic [DATA_W-1:0]         comp_b,
  output logic [DATA_W-1:0]         comp_c,
  input  logic [DATA_W-1:0]         comp_d,
  input  logic                      comp_rdy,
  output logic                      abort,
  output logic [ID_W-1:0]           abort_id,
  output logic                      busy,
  output sc_state_e                 state_dbg
);

  // Handshakes: a transfer happens on an edge where valid & ready are both
  // high; valid and its payload hold unchanged until that edge.

  localparam int CNT_W = sc_max1($clog2(COMP_LATENCY));

  sc_state_e         state, state_n;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [DATA_W-1:0] c_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    assign c_arr[i] = req_c[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= WAIT_RDY;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    case (state)
      WAIT_RDY: if (comp_rdy) state_n = IDLE;
      IDLE: begin
        if (!comp_rdy) begin
          state_n = WAIT_RDY;
        end else if (pick_any) begin
          req_ready[pick_idx] = 1'b1;
          state_n             = EXEC;
        end
      end
      EXEC: begin
        if (!comp_rdy)       state_n = WAIT_RDY;
        else if (cnt == '0)  state_n = RESP;
      end
      RESP: if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = WAIT_RDY;
    endcase
  end

  // comp_d is captured COMP_LATENCY edges after the operands are registered.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      cnt       <= '0;
      comp_a    <= '0;
      comp_b    <= '0;
      comp_c    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_d     <= '0;
      abort     <= 1'b0;
      abort_id  <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (comp_rdy && pick_any) begin
            comp_a <= a_arr[pick_idx];
            comp_b <= b_arr[pick_idx];
            comp_c <= c_arr[pick_idx];
            rsp_id <= pick_idx;
            ptr    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt    <= CNT_W'(COMP_LATENCY - 1);
          end
        end
        EXEC: begin
          if (!comp_rdy) begin
            abort    <= 1'b1;
            abort_id <= rsp_id;
          end else if (cnt == '0) begin
            rsp_d     <= comp_d;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy      = (state == EXEC) || (state == RESP);
  assign state_dbg = state;

endmodule

// File: tb/tb_simple_comp_sched.sv
// Bench for simple_comp_sched: directed corner sequences, a grant-order table
// and randomized traffic checked against a round-robin/latency model.
module tb_simple_comp_sched;
  import simple_comp_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 16;
  localparam int COMP_LATENCY = 2;
  localparam int ID_W         = 2;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 exp_w;
  } vec_t;

  logic                      clock = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b, req_c;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_d;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         comp_a, comp_b, comp_c, comp_d;
  logic                      comp_rdy;
  logic                      abort;
  logic [ID_W-1:0]           abort_id;
  logic                      busy;
  sc_state_e                 state_dbg;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ID_W-1:0]   exp_id_q[$];
  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];
  logic [DATA_W-1:0] op_c [NUM_REQ];
  logic [DATA_W-1:0] comp_d_q;

  simple_comp_sched dut (
    .clock     (clock),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_d     (rsp_d),
    .rsp_ready (rsp_ready),
    .comp_a    (comp_a),
    .comp_b    (comp_b),
    .comp_c    (comp_c),
    .comp_d    (comp_d),
    .comp_rdy  (comp_rdy),
    .abort     (abort),
    .abort_id  (abort_id),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [DATA_W-1:0] ref_d(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
    logic [31:0] p;
    p = a * b + c;
    return p[DATA_W-1:0];
  endfunction

  function automatic int rr_model(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return 0;
  endfunction

  // Stand-in compute unit: d settles one edge after operands change,
  // inside the two-edge window the scheduler waits.
  always @(posedge clock) comp_d_q <= ref_d(comp_a, comp_b, comp_c);
  assign comp_d = comp_d_q;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [NUM_REQ-1:0] mask, input bit fixed,
                          input logic [DATA_W-1:0] val, input int exp_w,
                          output int waited);
    int w;
    bit got;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = fixed ? val : DATA_W'($urandom);
      op_b[i] = fixed ? val : DATA_W'($urandom);
      op_c[i] = fixed ? val : DATA_W'($urandom);
      req_a[i*DATA_W +: DATA_W] = op_a[i];
      req_b[i*DATA_W +: DATA_W] = op_b[i];
      req_c[i*DATA_W +: DATA_W] = op_c[i];
    end
    req_valid = mask;
    w = (exp_w < 0) ? rr_model(mask, m_ptr) : exp_w;
    waited = 0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clock);
      waited++;
      if (req_ready != '0) got = 1'b1;
    end
    check("grant_timeout", 32'(got), 1);
    if (!got) return;
    check("grant_onehot", 32'(req_ready), 32'(1) << w);
    check("busy_idle", 32'(busy), 0);
    m_ptr = (w + 1) % NUM_REQ;
    exp_q.push_back(ref_d(op_a[w], op_b[w], op_c[w]));
    exp_id_q.push_back(ID_W'(w));
    @(posedge clock);
    #1;
    req_valid = '0;
    check("comp_a", 32'(comp_a), 32'(op_a[w]));
    check("comp_b", 32'(comp_b), 32'(op_b[w]));
    check("comp_c", 32'(comp_c), 32'(op_c[w]));
  endtask

  task automatic finish_op(input int hold);
    int lat;
    bit got;
    logic [DATA_W-1:0] ed;
    logic [ID_W-1:0]   eid;
    rsp_ready = (hold == 0);
    lat = 1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clock);
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clock);
        lat++;
      end
    end
    check("rsp_timeout", 32'(got), 1);
    if (!got || exp_q.size() == 0) return;
    ed  = exp_q.pop_front();
    eid = exp_id_q.pop_front();
    check("rsp_latency", 32'(lat), COMP_LATENCY + 1);
    check("rsp_id", 32'(rsp_id), 32'(eid));
    check("rsp_d", 32'(rsp_d), 32'(ed));
    check("busy_resp", 32'(busy), 1);
    if (hold > 0) begin
      req_valid = '1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clock);
        @(negedge clock);
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_id", 32'(rsp_id), 32'(eid));
        check("hold_d", 32'(rsp_d), 32'(ed));
        check("hold_no_accept", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    check("rsp_drop", 32'(rsp_valid), 0);
    check("idle_after", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_comp_a"}, 32'(comp_a), 0);
    check({tag, "_comp_b"}, 32'(comp_b), 0);
    check({tag, "_comp_c"}, 32'(comp_c), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_d"}, 32'(rsp_d), 0);
    check({tag, "_abort"}, 32'(abort), 0);
    check({tag, "_abort_id"}, 32'(abort_id), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_state"}, 32'(state_dbg), 32'(WAIT_RDY));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   waited;
    vec_t tbl [11];
    logic [NUM_REQ-1:0] m;

    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};
    tbl[5]  = '{4'b1111, 1};
    tbl[6]  = '{4'b1010, 3};
    tbl[7]  = '{4'b0101, 0};
    tbl[8]  = '{4'b0110, 1};
    tbl[9]  = '{4'b1001, 3};
    tbl[10] = '{4'b0001, 0};

    rst       = 1'b1;
    comp_rdy  = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;

    // Ready gating: nothing is accepted while the unit is not ready.
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("gate_req_ready", 32'(req_ready), 0);
      check("gate_state", 32'(state_dbg), 32'(WAIT_RDY));
    end
    comp_rdy = 1'b1;
    start_op(4'b0001, 1'b0, '0, 0, waited);
    check("gate_one_cycle", 32'(waited), 1);
    finish_op(0);

    // Single fixed-operand op from requester 2.
    start_op(4'b0100, 1'b1, 16'h0fff, 2, waited);
    finish_op(0);

    // Backpressure: result held for 10 cycles.
    start_op(4'b0001, 1'b1, 16'h0666, 0, waited);
    finish_op(10);

    // Abort during EXEC of requester 1.
    start_op(4'b0010, 1'b0, '0, 1, waited);
    comp_rdy = 1'b0;
    @(posedge clock);
    #1;
    check("abort_pulse", 32'(abort), 1);
    check("abort_id", 32'(abort_id), 1);
    check("abort_state", 32'(state_dbg), 32'(WAIT_RDY));
    check("abort_no_rsp", 32'(rsp_valid), 0);
    comp_rdy = 1'b1;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(exp_id_q.pop_back());
    end
    @(posedge clock);
    #1;
    check("abort_one_cycle", 32'(abort), 0);
    check("abort_id_hold", 32'(abort_id), 1);
    check("abort_recover", 32'(state_dbg), 32'(IDLE));
    start_op(4'b1111, 1'b0, '0, 2, waited);
    finish_op(0);

    // Reset in the middle of an op.
    start_op(4'b0100, 1'b0, '0, 2, waited);
    req_valid = '1;
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(exp_id_q.pop_back());
    end
    m_ptr = 0;
    @(posedge clock);
    #1;
    rst = 1'b1;

    // Grant-order table.
    for (int i = 0; i < 11; i++) begin
      start_op(tbl[i].mask, 1'b0, '0, tbl[i].exp_w, waited);
      finish_op(i % 2);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      start_op(m, 1'b0, '0, -1, waited);
      finish_op(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
